// File: rtl/noc_pkg.sv
// Shared NoC link types and helpers, used by both the TX injector and the RX-side credit logic.
package noc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Bits needed to hold a credit count from 0 up to and including depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_credit_flit_tx_if.sv
// AXI-Stream beat interface feeding the flit injector.
interface axis_credit_flit_tx_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TID_WIDTH   = 2,
  parameter int TDEST_WIDTH = 2
);

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);

endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for a credit-based link: starts full, spends one per issued flit,
// regains one per returned credit pulse, and flags credits returned beyond capacity.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = credit_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          credit_in,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic at_full;

  assign at_full = (count == FULL);
  assign nonzero = (count != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of the order the simulator evaluates processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= FULL;
      overflow <= 1'b0;
    end else begin
      unique case ({issue, credit_in})
        2'b10: count <= count - ONE;
        2'b01: begin
          // A credit at full capacity means the downstream side miscounted; keep the
          // count saturated and latch the error until reset.
          if (at_full) overflow <= 1'b1;
          else         count    <= count + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_credit_flit_tx.sv
// Router-port injector: accepts AXI-Stream beats, serialises each into flits and sends
// them over a credit-controlled router link, one flit per cycle while credits remain.
module axis_credit_flit_tx
  import noc_pkg::*;
#(
  parameter  int TDATA_WIDTH          = 32,
  parameter  int TID_WIDTH            = 2,
  parameter  int TDEST_WIDTH          = 2,
  parameter  int SERIALIZATION_FACTOR = 1,
  parameter  int FLIT_BUFFER_DEPTH    = 8,
  localparam int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
  localparam int CW                   = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  axis_credit_flit_tx_if.slave  axis_in,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CW-1:0]         credits_avail,
  output logic                  credit_overflow
);

  localparam int              SF       = SERIALIZATION_FACTOR;
  localparam int              IDX_W    = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SF - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  tx_state_e                     state, state_next;
  logic [SF-1:0][FLIT_WIDTH-1:0] hold_flits;
  logic                          hold_last;
  logic [DEST_WIDTH-1:0]         hold_dest;
  logic [IDX_W-1:0]              idx, idx_next;
  logic [FLIT_WIDTH-1:0]         cur_flit;
  logic                          credit_nonzero;
  logic                          issue;
  logic                          last_flit;
  logic                          load;
  logic                          tready;

  noc_credit_counter #(
    .DEPTH (FLIT_BUFFER_DEPTH)
  ) u_credit (
    .clk       (clk_noc),
    .rst_n     (rst_n),
    .issue     (issue),
    .credit_in (credit_in),
    .count     (credits_avail),
    .nonzero   (credit_nonzero),
    .overflow  (credit_overflow)
  );

  assign issue     = (state == SEND) && credit_nonzero;
  assign last_flit = (idx == LAST_IDX);

  // Upstream must never see an accept while the link is held in reset.
  assign axis_in.tready = tready && rst_n;

  if (SF == 1) begin : g_single_flit
    assign cur_flit = hold_flits[0];
  end else begin : g_multi_flit
    assign cur_flit = hold_flits[idx];
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    tready     = 1'b0;
    unique case (state)
      IDLE: begin
        tready = 1'b1;
        if (axis_in.tvalid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (issue) begin
          if (last_flit) begin
            // Accepting during the final flit lets beats stream with no idle cycle.
            tready = 1'b1;
            if (axis_in.tvalid) begin
              load     = 1'b1;
              idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + IDX_ONE;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: the holding register has no reset; it is only read while in SEND, and SEND
  // is only entered through a load, so its post-reset contents never reach the outputs.
  always_ff @(posedge clk_noc) begin
    if (load) begin
      hold_flits <= axis_in.tdata;
      hold_last  <= axis_in.tlast;
      hold_dest  <= {axis_in.tid, axis_in.tdest};
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= issue;
      if (issue) begin
        data_out    <= cur_flit;
        dest_out    <= hold_dest;
        is_tail_out <= hold_last && last_flit;
      end
    end
  end

endmodule

// File: tb/tb_axis_credit_flit_tx.sv
// Bench for axis_credit_flit_tx: one SF=1 and one SF=4 instance, each compared every
// cycle against a beat/flit/credit model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_axis_credit_flit_tx;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, index 0 = SF=1 instance, index 1 = SF=4 instance.
  logic        tvalid    [2];
  logic [31:0] tdata     [2];
  logic        tlast     [2];
  logic [1:0]  tid       [2];
  logic [1:0]  tdest     [2];
  logic        credit_in [2];

  logic        o_tready [2];
  logic        o_send   [2];
  logic        o_tail   [2];
  logic        o_ovf    [2];
  logic [31:0] o_data   [2];
  logic [3:0]  o_dest   [2];
  logic [3:0]  o_cred   [2];

  logic [31:0] d0_data;
  logic [7:0]  d1_data;
  logic [3:0]  d0_dest, d1_dest, d0_cred, d1_cred;
  logic        d0_send, d1_send, d0_tail, d1_tail, d0_ovf, d1_ovf;

  axis_credit_flit_tx_if #(.TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2)) ax0 ();
  axis_credit_flit_tx_if #(.TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2)) ax1 ();

  assign ax0.tvalid = tvalid[0];
  assign ax0.tdata  = tdata[0];
  assign ax0.tlast  = tlast[0];
  assign ax0.tid    = tid[0];
  assign ax0.tdest  = tdest[0];
  assign ax1.tvalid = tvalid[1];
  assign ax1.tdata  = tdata[1];
  assign ax1.tlast  = tlast[1];
  assign ax1.tid    = tid[1];
  assign ax1.tdest  = tdest[1];

  axis_credit_flit_tx #(
    .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2),
    .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut_sf1 (
    .clk_noc(clk), .rst_n(rst_n), .axis_in(ax0),
    .data_out(d0_data), .dest_out(d0_dest), .is_tail_out(d0_tail), .send_out(d0_send),
    .credit_in(credit_in[0]), .credits_avail(d0_cred), .credit_overflow(d0_ovf)
  );

  axis_credit_flit_tx #(
    .TDATA_WIDTH(32), .TID_WIDTH(2), .TDEST_WIDTH(2),
    .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(DEPTH)
  ) dut_sf4 (
    .clk_noc(clk), .rst_n(rst_n), .axis_in(ax1),
    .data_out(d1_data), .dest_out(d1_dest), .is_tail_out(d1_tail), .send_out(d1_send),
    .credit_in(credit_in[1]), .credits_avail(d1_cred), .credit_overflow(d1_ovf)
  );

  assign o_tready[0] = ax0.tready;
  assign o_tready[1] = ax1.tready;
  assign o_send[0] = d0_send;
  assign o_send[1] = d1_send;
  assign o_tail[0] = d0_tail;
  assign o_tail[1] = d1_tail;
  assign o_ovf[0]  = d0_ovf;
  assign o_ovf[1]  = d1_ovf;
  assign o_data[0] = d0_data;
  assign o_data[1] = {24'h0, d1_data};
  assign o_dest[0] = d0_dest;
  assign o_dest[1] = d1_dest;
  assign o_cred[0] = d0_cred;
  assign o_cred[1] = d1_cred;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the held beat, how many of its flits remain, the credit count, and the
  // output values the link should show after the coming edge.
  logic [31:0] beat_data  [2];
  logic        beat_last  [2];
  logic [3:0]  beat_dest  [2];
  int          flits_left [2];
  int          cred       [2];
  logic        ovf        [2];
  logic        e_send     [2];
  logic [31:0] e_data     [2];
  logic [3:0]  e_dest     [2];
  logic        e_tail     [2];
  int          sent       [2];
  logic [32:0] got1 [$];

  task automatic model_step(input int d);
    int          sf, fw, k, c0;
    bit          can_issue, exp_tready;
    logic [63:0] mask;
    string       tag;
    sf   = (d == 0) ? 1 : 4;
    fw   = 32 / sf;
    mask = (64'd1 << fw) - 64'd1;
    tag  = $sformatf("sf%0d", sf);
    if (rst_n !== 1'b1) begin
      flits_left[d] = 0;
      cred[d]       = DEPTH;
      ovf[d]        = 1'b0;
      e_send[d]     = 1'b0;
      e_data[d]     = '0;
      e_dest[d]     = '0;
      e_tail[d]     = 1'b0;
    end
    can_issue  = (rst_n === 1'b1) && (flits_left[d] > 0) && (cred[d] > 0);
    exp_tready = (rst_n === 1'b1) && ((flits_left[d] == 0) || (can_issue && flits_left[d] == 1));
    check({tag, "_send"},   64'(o_send[d]),   64'(e_send[d]));
    check({tag, "_data"},   64'(o_data[d]),   64'(e_data[d]));
    check({tag, "_dest"},   64'(o_dest[d]),   64'(e_dest[d]));
    check({tag, "_tail"},   64'(o_tail[d]),   64'(e_tail[d]));
    check({tag, "_credit"}, 64'(o_cred[d]),   64'(cred[d]));
    check({tag, "_ovf"},    64'(o_ovf[d]),    64'(ovf[d]));
    check({tag, "_tready"}, 64'(o_tready[d]), 64'(exp_tready));
    if (o_send[d] === 1'b1) begin
      sent[d]++;
      if (d == 1) got1.push_back({o_tail[d], o_data[d]});
    end
    if (rst_n !== 1'b1) return;
    c0        = cred[d];
    e_send[d] = can_issue;
    if (can_issue) begin
      k             = sf - flits_left[d];
      e_data[d]     = 32'((64'(beat_data[d]) >> (k * fw)) & mask);
      e_dest[d]     = beat_dest[d];
      e_tail[d]     = beat_last[d] && (flits_left[d] == 1);
      flits_left[d] = flits_left[d] - 1;
      cred[d]       = cred[d] - 1;
    end
    if (credit_in[d]) begin
      if (c0 == DEPTH && !can_issue) ovf[d] = 1'b1;
      else                           cred[d] = cred[d] + 1;
    end
    if (tvalid[d] && exp_tready) begin
      beat_data[d]  = tdata[d];
      beat_last[d]  = tlast[d];
      beat_dest[d]  = {tid[d], tdest[d]};
      flits_left[d] = sf;
    end
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [31:0] data, input logic last,
                      input logic [1:0] id, input logic [1:0] dst);
    int n;
    @(posedge clk);
    #1;
    tvalid[d] = 1'b1;
    tdata[d]  = data;
    tlast[d]  = last;
    tid[d]    = id;
    tdest[d]  = dst;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_tready[d] !== 1'b1 && n < 40);
    check($sformatf("push_accept_d%0d", d), 64'(o_tready[d]), 64'd1);
    @(posedge clk);
    #1;
    tvalid[d] = 1'b0;
  endtask

  task automatic pulse_credit(input int d, input int cycles);
    @(posedge clk);
    #1;
    credit_in[d] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    credit_in[d] = 1'b0;
  endtask

  task automatic wait_sent(input int d, input int target);
    int n;
    n = 0;
    while (sent[d] < target && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("flit_count_d%0d", d), 64'(sent[d]), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      tvalid[d] = 1'b0; tdata[d] = '0; tlast[d] = 1'b0;
      tid[d] = '0; tdest[d] = '0; credit_in[d] = 1'b0; sent[d] = 0;
    end
    repeat (3) tick();
    check("reset_cred_sf1", 64'(o_cred[0]), 64'd8);
    check("reset_tready_sf1", 64'(o_tready[0]), 64'd0);
    check("reset_send_sf4", 64'(o_send[1]), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single-flit beat: payload, {tid,tdest} and tail on the first send.
    push(0, 32'hDEADBEEF, 1'b1, 2'd1, 2'd2);
    n = 0;
    while (o_send[0] !== 1'b1 && n < 10) begin tick(); n++; end
    check("t1_send",  64'(o_send[0]), 64'd1);
    check("t1_data",  64'(o_data[0]), 64'hDEADBEEF);
    check("t1_dest",  64'(o_dest[0]), 64'h6);
    check("t1_tail",  64'(o_tail[0]), 64'd1);
    check("t1_cred",  64'(o_cred[0]), 64'd7);
    pulse_credit(0, 1);
    tick();
    check("t1_cred_back", 64'(o_cred[0]), 64'd8);

    // Spurious credit at full capacity on the idle SF=4 instance.
    pulse_credit(1, 1);
    tick();
    check("ovf_cred", 64'(o_cred[1]), 64'd8);
    check("ovf_flag", 64'(o_ovf[1]), 64'd1);

    // SF=4: four flits LSB first, tail only on the last, tready low for three cycles.
    push(1, 32'h44332211, 1'b1, 2'd0, 2'd3);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_tready[1] === 1'b1) break;
      n++;
    end
    check("sf4_tready_low_cycles", 64'(n), 64'd3);
    wait_sent(1, 4);
    check("sf4_flit0", 64'(got1[0]), {31'h0, 1'b0, 32'h11});
    check("sf4_flit1", 64'(got1[1]), {31'h0, 1'b0, 32'h22});
    check("sf4_flit2", 64'(got1[2]), {31'h0, 1'b0, 32'h33});
    check("sf4_flit3", 64'(got1[3]), {31'h0, 1'b1, 32'h44});
    check("sf4_cred",  64'(o_cred[1]), 64'd4);
    check("sf4_ovf_sticky", 64'(o_ovf[1]), 64'd1);

    // Starvation: nine beats fit (eight sent, one held), the tenth waits.
    for (int i = 0; i < 9; i++) push(0, 32'hA000_0000 + i, 1'b1, 2'd2, 2'd1);
    @(posedge clk);
    #1;
    tvalid[0] = 1'b1;
    tdata[0]  = 32'hA000_0009;
    repeat (5) tick();
    check("starve_sent", 64'(sent[0]), 64'd9);
    check("starve_cred", 64'(o_cred[0]), 64'd0);
    check("starve_tready", 64'(o_tready[0]), 64'd0);
    pulse_credit(0, 1);
    @(posedge clk);
    #1;
    tvalid[0] = 1'b0;
    repeat (4) tick();
    check("starve_one_more", 64'(sent[0]), 64'd10);
    check("starve_cred_again", 64'(o_cred[0]), 64'd0);
    pulse_credit(0, 1);
    wait_sent(0, 11);
    pulse_credit(0, 3);
    tick();
    check("credit_three", 64'(o_cred[0]), 64'd3);

    // Back-to-back beats with a credit returned on every issue cycle.
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      tvalid[0]    = 1'b1;
      tdata[0]     = 32'h1000_0000 + i;
      tlast[0]     = (i % 2 == 1);
      credit_in[0] = (i > 0);
      @(posedge clk);
      #1;
      check($sformatf("stream_cred_%0d", i), 64'(o_cred[0]), 64'd3);
    end
    tvalid[0]    = 1'b0;
    credit_in[0] = 1'b1;
    @(posedge clk);
    #1;
    credit_in[0] = 1'b0;
    check("stream_cred_end", 64'(o_cred[0]), 64'd3);
    wait_sent(0, 17);

    // Reset in the middle of a four-flit beat.
    got1.delete();
    push(1, 32'h88776655, 1'b0, 2'd2, 2'd1);
    n = 0;
    while (got1.size() < 2 && n < 20) begin tick(); n++; end
    check("mid_two_flits", 64'(got1.size()), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_send", 64'(o_send[1]), 64'd0);
    check("mid_rst_cred", 64'(o_cred[1]), 64'd8);
    check("mid_rst_ovf",  64'(o_ovf[1]),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    got1.delete();
    sent[1] = 0;
    push(1, 32'hAABBCCDD, 1'b1, 2'd3, 2'd0);
    wait_sent(1, 4);
    check("post_rst_flit0", 64'(got1[0]), {31'h0, 1'b0, 32'hDD});
    check("post_rst_flit3", 64'(got1[3]), {31'h0, 1'b1, 32'hAA});

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
